d_reg_pipe: RTL and testbench
=============================

// Module: d_reg_pipe
// PURPOSE
//  Parametrised successor to the single D flip-flop: a DEPTH-stage, WIDTH-bit register pipeline with
//  valid/ready flow control, bubble collapsing, synchronous flush and occupancy count. Retimes datapaths
//  between producer and consumer blocks while honouring backpressure. Never drops or duplicates a word.
// PARAMETERS
//  WIDTH      8    data bits per stage (>=1)
//  DEPTH      3    number of register stages (>=1); zero-stall latency in cycles
//  RESET_VAL  0    value loaded into every data register on rst (WIDTH bits)
// PORTS
//  clk        in   1                    single clock, all state updates on posedge clk
//  rst        in   1                    synchronous, active-high reset
//  flush      in   1                    synchronous discard of all held words
//  in_valid   in   1                    producer offers in_data
//  in_ready   out  1                    pipeline accepts in_data this cycle
//  in_data    in   WIDTH                input word
//  out_valid  out  1                    last stage holds a valid word
//  out_ready  in   1                    consumer takes out_data this cycle
//  out_data   out  WIDTH                word in last stage
//  count      out  $clog2(DEPTH+1)      number of valid stages
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. Priority: rst > flush > normal operation.
//  - Reset: all valid bits 0, all data regs = RESET_VAL. Hence out_valid=0, out_data=RESET_VAL,
//    count=0, in_ready=1 in the cycle after rst is sampled (in_ready is 0 while rst is high).
//  - Stage i (0=input, DEPTH-1=output) holds v[i], d[i]. take[DEPTH-1]=out_ready; take[i]=acc[i+1];
//    acc[i]=!v[i] | take[i]. in_ready=acc[0] & !flush & !rst. Combinational ready chain, no skid buffer.
//  - Stage 0 loads in_data when in_valid & in_ready; stage i>0 loads d[i-1] when acc[i] & v[i-1].
//    v[i] next = (loaded) ? source valid : (v[i] & !take[i]). Data regs change only on load.
//  - Bubble collapsing: a stalled output never stalls an empty upstream stage; words advance into holes.
//  - Latency: a word accepted at edge N appears on out_data/out_valid after edge N+DEPTH-1 if no stalls.
//  - Throughput: one word/cycle with out_ready=1 continuously; full pipe + out_ready=1 accepts and
//    emits in the same cycle (count stays DEPTH).
//  - Transfer out occurs when out_valid & out_ready; out_data stable while out_valid & !out_ready.
//  - flush: next edge clears all v[i]; data regs unchanged; no handshake completes on either side
//    in the flush cycle (in_ready=0; an out transfer in that cycle is void by contract).
//  - rst or flush mid-operation: in-flight words discarded, no partial state retained.
//  - count = popcount(v) registered alongside v; range 0..DEPTH, never wraps.
//  - in_valid/in_data ignored when in_ready=0; producer must hold them (standard valid/ready rules).
// STRUCTURE
//  - Package d_reg_pkg: function clog2, localparam/typedef for count width; shared with future reg blocks.
//  - Sub-module d_reg_stage (WIDTH, RESET_VAL): one valid+data register with load/take/flush/rst;
//    top instantiates DEPTH copies via generate and builds the acc/take chain and count register.
// TESTING  (WIDTH=8, DEPTH=3, RESET_VAL=8'hA5 unless noted)
//  1 rst=1 two cycles with in_valid=1 -> in_ready=0 during rst; after: out_valid=0, out_data=A5, count=0.
//  2 out_ready=1, push 11,22,33 back-to-back -> 11 at out 2 edges after its accept, then 22,33 on
//    consecutive cycles; count 1,2,3 then drains to 0.
//  3 out_ready=0, push 4 words 01..04 -> 01..03 accepted, in_ready=0, count=3, out_data=01 stable;
//    raise out_ready -> in_ready=1 same cycle, 04 accepted, output order 01,02,03,04.
//  4 out_ready=0, single word 77 reaches stage 2; push 88 -> 88 reaches stage 1 in 2 cycles (collapse), count=2.
//  5 pipe full (count=3), flush=1 one cycle with in_valid=1 -> in_ready=0; next cycle count=0, out_valid=0.
//  6 DEPTH=1 build: rst mid-transfer, then stream 5 words with random out_ready -> scoreboard in-order,
//    no loss/duplication; count never exceeds 1.

Source files
------------

// File: rtl/d_reg_pkg.sv
// d_reg_pkg: shared helpers for register pipeline blocks
package d_reg_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // width able to hold 0..depth, never narrower than one bit
    function automatic int cnt_w(input int depth);
        return (clog2(depth + 1) < 1) ? 1 : clog2(depth + 1);
    endfunction

    typedef logic [cnt_w(DEF_DEPTH)-1:0] def_cnt_t;
endpackage

// File: rtl/d_reg_stage.sv
// d_reg_stage: one valid+data register of the pipeline
module d_reg_stage
    import d_reg_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic             take,
    input  logic [WIDTH-1:0] src,
    output logic             v,
    output logic [WIDTH-1:0] d
);
    // flush drops the valid bit only; data is left as it was
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
            d <= RESET_VAL;
        end else if (flush) begin
            v <= 1'b0;
        end else if (load) begin
            v <= 1'b1;
            d <= src;
        end else if (take) begin
            v <= 1'b0;
        end
    end
endmodule

// File: rtl/d_reg_pipe.sv
// d_reg_pipe: DEPTH-stage valid/ready register pipeline with bubble collapsing
module d_reg_pipe
    import d_reg_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [cnt_w(DEPTH)-1:0]   count
);
    localparam int CW = cnt_w(DEPTH);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] ld;
    logic [DEPTH:0]   acc;
    logic [WIDTH-1:0] d   [DEPTH];
    logic [WIDTH-1:0] src [DEPTH];

    // acc[DEPTH] is the consumer; a stage accepts when empty or when it is emptied downstream
    always_comb begin
        acc = '0;
        acc[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) acc[i] = !v[i] | acc[i+1];
    end

    assign in_ready  = acc[0] & !flush & !rst;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    for (genvar g = 0; g < DEPTH; g++) begin : st
        if (g == 0) begin : head
            assign ld[g]  = in_valid & in_ready;
            assign src[g] = in_data;
        end else begin : body
            assign ld[g]  = acc[g] & v[g-1];
            assign src[g] = d[g-1];
        end
        d_reg_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
            .clk  (clk),
            .rst  (rst),
            .flush(flush),
            .load (ld[g]),
            .take (acc[g+1]),
            .src  (src[g]),
            .v    (v[g]),
            .d    (d[g])
        );
    end

    // internal moves conserve words, so occupancy tracks entries minus exits
    always_ff @(posedge clk) begin
        if (rst || flush) count <= '0;
        else count <= count + CW'(in_valid & in_ready) - CW'(out_valid & out_ready);
    end
endmodule

// File: tb/tb_d_reg_pipe.sv
// tb_d_reg_pipe: vector table plus queue-model random check of DEPTH=3 and DEPTH=1 pipes
module tb_d_reg_pipe;
    typedef struct {
        logic       iv;
        logic [7:0] din;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_d;
        int         e_c;
    } vec_t;

    logic       clk, rst, flush, iv, ordy;
    logic [7:0] din;
    logic       ir0, ov0, ir1, ov1;
    logic [7:0] od0, od1;
    logic [1:0] cnt0;
    logic       cnt1;

    int   total, bad;
    int   e;
    int   qd [2][8];
    int   qe [2][8];
    int   qh [2];
    int   qn [2];
    bit   armed;
    logic pre_ir0, pre_ir1;
    vec_t tbl [32];
    int   ntbl;

    d_reg_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv), .in_ready(ir0), .in_data(din),
        .out_valid(ov0), .out_ready(ordy), .out_data(od0), .count(cnt0)
    );

    d_reg_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'hA5)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv), .in_ready(ir1), .in_data(din),
        .out_valid(ov1), .out_ready(ordy), .out_data(od1), .count(cnt1)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int a, input int x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, a, x, $time);
        end
    endtask

    task automatic add(input logic v_, input logic [7:0] d_, input logic r_,
                       input logic eir, input logic eov, input logic [7:0] ed, input int ec);
        tbl[ntbl] = '{v_, d_, r_, eir, eov, ed, ec};
        ntbl++;
    endtask

    // the head word is never blocked, so it shows after DEPTH-1 edges; ready only drops when full and stalled
    task automatic tick();
        bit    fi [2];
        bit    fo [2];
        bit    eir, eov;
        int    dep, ac;
        logic  air, aov;
        logic [7:0] ad;
        string p;
        #1;
        for (int k = 0; k < 2; k++) begin
            dep = (k == 0) ? 3 : 1;
            p   = (k == 0) ? "d0" : "d1";
            air = (k == 0) ? ir0 : ir1;
            aov = (k == 0) ? ov0 : ov1;
            ad  = (k == 0) ? od0 : od1;
            ac  = (k == 0) ? int'(cnt0) : int'(cnt1);
            eir = !rst && !flush && !(qn[k] == dep && !ordy);
            eov = qn[k] > 0 && (e - qe[k][qh[k]] >= dep - 1);
            chk({p, "_in_ready"}, int'(air), int'(eir));
            if (armed) begin
                chk({p, "_out_valid"}, int'(aov), int'(eov));
                if (eov) chk({p, "_out_data"}, int'(ad), qd[k][qh[k]]);
                chk({p, "_count"}, ac, qn[k]);
            end
            fi[k] = iv && eir;
            fo[k] = eov && ordy && !flush && !rst;
        end
        pre_ir0 = ir0;
        pre_ir1 = ir1;
        @(posedge clk);
        e++;
        for (int k = 0; k < 2; k++) begin
            if (rst || flush) begin
                qh[k] = 0;
                qn[k] = 0;
            end else begin
                if (fo[k]) begin
                    qh[k] = (qh[k] + 1) % 8;
                    qn[k]--;
                end
                if (fi[k]) begin
                    qd[k][(qh[k] + qn[k]) % 8] = int'(din);
                    qe[k][(qh[k] + qn[k]) % 8] = e;
                    qn[k]++;
                end
            end
        end
        #1;
    endtask

    initial begin
        int tries;
        total = 0; bad = 0; e = 0; armed = 0; ntbl = 0;
        qh = '{0, 0}; qn = '{0, 0};
        rst = 1; flush = 0; iv = 1; din = 8'h3C; ordy = 0;

        add(1, 8'h11, 1, 1, 0, 8'hA5, 1);
        add(1, 8'h22, 1, 1, 0, 8'hA5, 2);
        add(1, 8'h33, 1, 1, 1, 8'h11, 3);
        add(0, 8'h00, 1, 1, 1, 8'h22, 2);
        add(0, 8'h00, 1, 1, 1, 8'h33, 1);
        add(0, 8'h00, 1, 1, 0, 8'h33, 0);
        add(1, 8'h01, 0, 1, 0, 8'h33, 1);
        add(1, 8'h02, 0, 1, 0, 8'h33, 2);
        add(1, 8'h03, 0, 1, 1, 8'h01, 3);
        add(1, 8'h04, 0, 0, 1, 8'h01, 3);
        add(1, 8'h04, 0, 0, 1, 8'h01, 3);
        add(1, 8'h04, 1, 1, 1, 8'h02, 3);
        add(0, 8'h00, 1, 1, 1, 8'h03, 2);
        add(0, 8'h00, 1, 1, 1, 8'h04, 1);
        add(0, 8'h00, 1, 1, 0, 8'h04, 0);
        add(1, 8'h77, 0, 1, 0, 8'h04, 1);
        add(0, 8'h00, 0, 1, 0, 8'h04, 1);
        add(0, 8'h00, 0, 1, 1, 8'h77, 1);
        add(1, 8'h88, 0, 1, 1, 8'h77, 2);
        add(0, 8'h00, 0, 1, 1, 8'h77, 2);
        add(0, 8'h00, 0, 1, 1, 8'h77, 2);
        add(0, 8'h00, 1, 1, 1, 8'h88, 1);
        add(0, 8'h00, 1, 1, 0, 8'h88, 0);

        @(posedge clk);
        #1;
        tick();
        chk("rst_in_ready_d0", int'(pre_ir0), 0);
        tick();
        chk("rst_in_ready_d1", int'(pre_ir1), 0);
        rst = 0; iv = 0;
        armed = 1;
        #1;
        chk("rst_out_valid", int'(ov0), 0);
        chk("rst_out_data", int'(od0), 'hA5);
        chk("rst_count", int'(cnt0), 0);
        chk("rst_in_ready_after", int'(ir0), 1);
        chk("rst_out_data_d1", int'(od1), 'hA5);

        for (int i = 0; i < ntbl; i++) begin
            iv = tbl[i].iv; din = tbl[i].din; ordy = tbl[i].ordy;
            tick();
            chk($sformatf("vec%0d_in_ready", i), int'(pre_ir0), int'(tbl[i].e_ir));
            chk($sformatf("vec%0d_out_valid", i), int'(ov0), int'(tbl[i].e_ov));
            chk($sformatf("vec%0d_out_data", i), int'(od0), int'(tbl[i].e_d));
            chk($sformatf("vec%0d_count", i), int'(cnt0), tbl[i].e_c);
        end

        ordy = 0; iv = 1;
        din = 8'hAA; tick();
        din = 8'hBB; tick();
        din = 8'hCC; tick();
        chk("full_count", int'(cnt0), 3);
        flush = 1; din = 8'hDD;
        tick();
        chk("flush_in_ready_d0", int'(pre_ir0), 0);
        chk("flush_in_ready_d1", int'(pre_ir1), 0);
        flush = 0; iv = 0;
        #1;
        chk("flush_count", int'(cnt0), 0);
        chk("flush_out_valid", int'(ov0), 0);
        chk("flush_data_kept", int'(od0), 'hAA);

        iv = 1; din = 8'h5A; ordy = 1;
        tick();
        din = 8'h5B; rst = 1;
        tick();
        rst = 0;
        for (int w = 0; w < 5; w++) begin
            iv = 1; din = 8'h60 + 8'(w);
            tries = 0;
            do begin
                ordy = 1'($urandom % 2);
                tick();
                tries++;
            end while (!pre_ir1 && tries < 20);
            chk($sformatf("d1_accept%0d", w), int'(pre_ir1), 1);
        end
        iv = 0; ordy = 1;
        repeat (4) tick();
        chk("d1_drained_count", int'(cnt1), 0);
        chk("d1_drained_valid", int'(ov1), 0);

        for (int n = 0; n < 400; n++) begin
            if (!(iv && !pre_ir0)) begin
                iv  = ($urandom % 3) != 0;
                din = 8'($urandom);
            end
            ordy  = ($urandom % 4) != 0;
            flush = ($urandom % 40) == 0;
            rst   = ($urandom % 60) == 0;
            tick();
        end
        rst = 0; flush = 0; iv = 0; ordy = 1;
        repeat (5) tick();
        chk("final_count_d0", int'(cnt0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
